// File: rtl/sipo_capture_pkg.sv
// Shared types and helpers for the serial-in/parallel-out capture block.
package sipo_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_e;

    // Counter must hold the value OUTPUT_WIDTH without wrapping.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/sipo_capture_if.sv
// Handshake/data bundle between a serial source/consumer and sipo_capture.
// SIPO_CAPTURE_PARITY_EN adds the parity_err signal.
interface sipo_capture_if #(
    parameter int OUTPUT_WIDTH = 8
);
    logic                    frame_start;
    logic                    shift_en;
    logic                    serial_in;
    logic                    data_ack;
    logic [OUTPUT_WIDTH-1:0] data;
    logic                    data_valid;
    logic                    busy;
    logic                    overrun;
`ifdef SIPO_CAPTURE_PARITY_EN
    logic                    parity_err;
`endif

    modport master (
`ifdef SIPO_CAPTURE_PARITY_EN
        input  parity_err,
`endif
        output frame_start, shift_en, serial_in, data_ack,
        input  data, data_valid, busy, overrun
    );

    modport slave (
`ifdef SIPO_CAPTURE_PARITY_EN
        output parity_err,
`endif
        input  frame_start, shift_en, serial_in, data_ack,
        output data, data_valid, busy, overrun
    );

endinterface

// File: rtl/sipo_capture_shifter.sv
// Shift register datapath for sipo_capture; next_word_o is the value the
// register takes on a shifting edge, so the last bit can be captured directly.
module sipo_shifter #(
    parameter int OUTPUT_WIDTH = 8,
    parameter bit SHIFT_LEFT   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    shift_en,
    input  logic                    serial_in,
    output logic [OUTPUT_WIDTH-1:0] word_o,
    output logic [OUTPUT_WIDTH-1:0] next_word_o
);

    logic [OUTPUT_WIDTH-1:0] word_q;
    logic [OUTPUT_WIDTH-1:0] word_d;

    // LSB-first inserts at the top so the first bit walks down to bit 0.
    assign word_d = SHIFT_LEFT ? {word_q[OUTPUT_WIDTH-2:0], serial_in}
                               : {serial_in, word_q[OUTPUT_WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_q <= '0;
        end else if (clear) begin
            word_q <= '0;
        end else if (shift_en) begin
            word_q <= word_d;
        end
    end

    assign word_o      = word_q;
    assign next_word_o = word_d;

endmodule

// File: rtl/sipo_capture.sv
// Frame-based serial-to-parallel capture with holding register and overrun flag.
// Define SIPO_CAPTURE_PARITY_EN for a trailing even-parity bit and parity_err.
module sipo_capture
    import sipo_pkg::*;
#(
    parameter int OUTPUT_WIDTH = 8,
    parameter bit SHIFT_LEFT   = 1'b1
) (
    input logic           clk,
    input logic           rst_n,
    sipo_capture_if.slave bus
);

    localparam int                CNT_W    = cnt_width(OUTPUT_WIDTH);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(OUTPUT_WIDTH - 1);

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [OUTPUT_WIDTH-1:0] data_q;
    logic                    valid_q;
    logic                    busy_q;
    logic                    overrun_q;
    logic [OUTPUT_WIDTH-1:0] word;
    logic [OUTPUT_WIDTH-1:0] word_d;
    logic [OUTPUT_WIDTH-1:0] load_d;
    logic                    shift_d;
    logic                    complete_d;

    // frame_start always wins over a same-cycle sample.
    assign shift_d = (state_q == SHIFT) && bus.shift_en && !bus.frame_start;

`ifdef SIPO_CAPTURE_PARITY_EN
    logic parity_err_q;
    assign complete_d = (state_q == PARITY) && bus.shift_en && !bus.frame_start;
    assign load_d     = word;
    assign bus.parity_err = parity_err_q;
`else
    assign complete_d = shift_d && (cnt_q == LAST_BIT);
    assign load_d     = word_d;
`endif

    sipo_shifter #(
        .OUTPUT_WIDTH (OUTPUT_WIDTH),
        .SHIFT_LEFT   (SHIFT_LEFT)
    ) u_shifter (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (bus.frame_start),
        .shift_en    (shift_d),
        .serial_in   (bus.serial_in),
        .word_o      (word),
        .next_word_o (word_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef SIPO_CAPTURE_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            if (bus.data_ack && valid_q) begin
                valid_q      <= 1'b0;
`ifdef SIPO_CAPTURE_PARITY_EN
                parity_err_q <= 1'b0;
`endif
            end
            // A completing frame overrides a same-edge acknowledge.
            if (complete_d) begin
                data_q  <= load_d;
                valid_q <= 1'b1;
                if (valid_q && !bus.data_ack) begin
                    overrun_q <= 1'b1;
                end
`ifdef SIPO_CAPTURE_PARITY_EN
                parity_err_q <= ^word ^ bus.serial_in;
`endif
            end

            case (state_q)
                IDLE: begin
                    if (bus.frame_start) begin
                        state_q <= SHIFT;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (bus.frame_start) begin
                        cnt_q <= '0;
                    end else if (bus.shift_en) begin
                        if (cnt_q == LAST_BIT) begin
`ifdef SIPO_CAPTURE_PARITY_EN
                            state_q <= PARITY;
                            cnt_q   <= cnt_q + 1'b1;
`else
                            state_q <= IDLE;
                            cnt_q   <= '0;
                            busy_q  <= 1'b0;
`endif
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (bus.frame_start) begin
                        state_q <= SHIFT;
                        cnt_q   <= '0;
                    end else if (bus.shift_en) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data       = data_q;
    assign bus.data_valid = valid_q;
    assign bus.busy       = busy_q;
    assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_sipo_capture.sv
// Bench for sipo_capture: an MSB-first and an LSB-first instance share one
// stimulus stream; directed table, hand sequences, then randomized traffic.
module tb_sipo_capture;

    localparam int W = 8;
`ifdef SIPO_CAPTURE_PARITY_EN
    localparam int FB = W + 1;
`else
    localparam int FB = W;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic fs, se, si, ack;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sipo_capture_if #(.OUTPUT_WIDTH(W)) bm ();
    sipo_capture_if #(.OUTPUT_WIDTH(W)) bl ();

    assign bm.frame_start = fs;
    assign bm.shift_en    = se;
    assign bm.serial_in   = si;
    assign bm.data_ack    = ack;
    assign bl.frame_start = fs;
    assign bl.shift_en    = se;
    assign bl.serial_in   = si;
    assign bl.data_ack    = ack;

    sipo_capture #(.OUTPUT_WIDTH(W), .SHIFT_LEFT(1'b1)) dut_msb (
        .clk(clk), .rst_n(rst_n), .bus(bm.slave));
    sipo_capture #(.OUTPUT_WIDTH(W), .SHIFT_LEFT(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .bus(bl.slave));

    // Reference model: a list of bits received since the last arm.
    bit         m_armed;
    bit         m_q[$];
    logic [W-1:0] m_msb, m_lsb;
    bit         m_valid, m_ovr, m_perr;

    task automatic model_update();
        bit done = 0;
        if (!rst_n) begin
            m_armed = 0; m_q.delete();
            m_msb = '0; m_lsb = '0; m_valid = 0; m_ovr = 0; m_perr = 0;
            return;
        end
        if (fs) begin
            m_armed = 1; m_q.delete();
        end else if (m_armed && se) begin
            m_q.push_back(si);
            if (m_q.size() == FB) done = 1;
        end
        if (done) begin
            logic [W-1:0] a = '0, b = '0;
            bit p = 0;
            for (int i = 0; i < W; i++) begin
                a[W-1-i] = m_q[i];
                b[i]     = m_q[i];
            end
            for (int i = 0; i < FB; i++) p ^= m_q[i];
            if (m_valid && !ack) m_ovr = 1;
            m_msb = a; m_lsb = b; m_valid = 1; m_perr = p;
            m_armed = 0; m_q.delete();
        end else if (ack && m_valid) begin
            m_valid = 0; m_perr = 0;
        end
    endtask

    task automatic step(input logic f, input logic s, input logic d,
                        input logic a, input logic r);
        fs = f; se = s; si = d; ack = a; rst_n = r;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [W-1:0] em, input logic [W-1:0] el,
                            input logic ev, input logic eb, input logic eo);
        chk({tag, ".data_msb"}, 32'(bm.data), 32'(em));
        chk({tag, ".data_lsb"}, 32'(bl.data), 32'(el));
        chk({tag, ".valid"},    32'(bm.data_valid), 32'(ev));
        chk({tag, ".busy"},     32'(bm.busy), 32'(eb));
        chk({tag, ".overrun"},  32'(bm.overrun), 32'(eo));
    endtask

    // Sends frame_start then the word MSB-first (plus parity bit p when
    // enabled); ack_last raises data_ack on the final sampling edge.
    task automatic send_word(input logic [W-1:0] w, input logic p, input logic ack_last);
        step(1, 0, 0, 0, 1);
        for (int i = W - 1; i >= 0; i--)
            step(0, 1, w[i], (FB == W && i == 0) ? ack_last : 1'b0, 1);
        if (FB != W) step(0, 1, p, ack_last, 1);
    endtask

    typedef struct {
        logic f, s, d, a, r;
        logic [W-1:0] em, el;
        logic ev, eb, eo;
    } vec_t;

    function automatic vec_t mk(logic f, logic s, logic d, logic a, logic r,
                                logic [W-1:0] em, logic [W-1:0] el,
                                logic ev, logic eb, logic eo);
        vec_t v;
        v.f = f; v.s = s; v.d = d; v.a = a; v.r = r;
        v.em = em; v.el = el; v.ev = ev; v.eb = eb; v.eo = eo;
        return v;
    endfunction

    initial begin
        vec_t tbl[$];
        logic [7:0] bits;
        fs = 0; se = 0; si = 0; ack = 0; rst_n = 0;

`ifndef SIPO_CAPTURE_PARITY_EN
        bits = 8'b11011000;
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 8'h00, 8'h00, 0, 1, 0));
        for (int i = 7; i >= 1; i--)
            tbl.push_back(mk(0, 1, bits[i], 0, 1, 8'h00, 8'h00, 0, 1, 0));
        tbl.push_back(mk(0, 1, bits[0], 0, 1, 8'hD8, 8'h1B, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 8'hD8, 8'h1B, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 1, 8'hD8, 8'h1B, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 1, 8'hD8, 8'h1B, 0, 1, 0));
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].f, tbl[i].s, tbl[i].d, tbl[i].a, tbl[i].r);
            chk_outs($sformatf("tbl%0d", i), tbl[i].em, tbl[i].el, tbl[i].ev, tbl[i].eb, tbl[i].eo);
        end
`else
        step(0, 0, 0, 0, 0);
        chk_outs("reset", 8'h00, 8'h00, 0, 0, 0);
        chk("reset.perr", 32'(bm.parity_err), 32'd0);
`endif

        // Overrun: second word lands while the first is unacknowledged.
        send_word(8'b00101000, 1'b0, 0);
        chk("ovr.first", 32'(bm.data), 32'h28);
        chk("ovr.first_valid", 32'(bm.data_valid), 32'd1);
        chk("ovr.first_noovr", 32'(bm.overrun), 32'd0);
        send_word(8'b11011000, 1'b0, 0);
        chk_outs("ovr.second", 8'hD8, 8'h1B, 1, 0, 1);
        step(0, 0, 0, 1, 1);
        chk_outs("ovr.ack", 8'hD8, 8'h1B, 0, 0, 1);

        // Mid-frame reset clears everything, stray shifts are ignored after.
        step(1, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 1);
        step(0, 0, 0, 0, 0);
        chk_outs("rst_mid", 8'h00, 8'h00, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 1, 0, 1);
            chk("rst_noframe.valid", 32'(bm.data_valid), 32'd0);
            chk("rst_noframe.busy", 32'(bm.busy), 32'd0);
        end

        // Completion coinciding with ack keeps valid high, no overrun.
        send_word(8'h5A, 1'b0, 0);
        chk("ackcol.first", 32'(bm.data_valid), 32'd1);
        send_word(8'h3C, 1'b0, 1);
        chk_outs("ackcol", 8'h3C, 8'h3C, 1, 0, 0);
        step(0, 0, 0, 1, 1);

        // Restart after a partial 1010 frame.
        step(1, 0, 0, 0, 1);
        step(0, 1, 1, 0, 1); step(0, 1, 0, 0, 1);
        step(0, 1, 1, 0, 1); step(0, 1, 0, 0, 1);
        send_word(8'hA5, 1'b0, 0);
        chk_outs("restart", 8'hA5, 8'hA5, 1, 0, 0);
        step(0, 0, 0, 1, 1);

`ifdef SIPO_CAPTURE_PARITY_EN
        send_word(8'hA5, 1'b0, 0);
        chk("par.good", 32'(bm.parity_err), 32'd0);
        chk("par.good_data", 32'(bm.data), 32'hA5);
        step(0, 0, 0, 1, 1);
        send_word(8'hA5, 1'b1, 0);
        chk("par.bad", 32'(bm.parity_err), 32'd1);
        chk("par.bad_valid", 32'(bm.data_valid), 32'd1);
        step(0, 0, 0, 1, 1);
        chk("par.ack", 32'(bm.parity_err), 32'd0);
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 23) == 0), ($urandom_range(0, 9) < 7), 1'($urandom),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 199) != 0));
            chk_outs("rand", m_msb, m_lsb, m_valid, m_armed, m_ovr);
`ifdef SIPO_CAPTURE_PARITY_EN
            chk("rand.perr", 32'(bm.parity_err), 32'(m_perr));
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sipo_capture.md
SIPO_CAPTURE -- requirements
Module: sipo_capture

Interface
REQ-001 Parameter OUTPUT_WIDTH, default 8: number of data bits per frame, legal range 2..32.
REQ-002 Parameter SHIFT_LEFT, default 1'b1: 1 = MSB-first, so the first bit lands in data[OUTPUT_WIDTH-1]; 0 = LSB-first, so the first bit lands in data[0].
REQ-003 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 Port frame_start, input, 1 bit: one-cycle pulse that arms reception of a new frame.
REQ-006 Port shift_en, input, 1 bit: serial_in is sampled on a rising edge only while shift_en=1.
REQ-007 Port serial_in, input, 1 bit: serial data.
REQ-008 Port data, output, OUTPUT_WIDTH bits: holding register containing the last completed word.
REQ-009 Port data_valid, output, 1 bit: level; data holds an unacknowledged word.
REQ-010 Port data_ack, input, 1 bit: consumer acknowledge.
REQ-011 Port busy, output, 1 bit: high in every state except IDLE.
REQ-012 Port overrun, output, 1 bit: sticky flag; a word completed while data_valid was still high.

Function
REQ-013 The FSM SHALL have states IDLE, SHIFT and PARITY; PARITY exists only per REQ-027.
REQ-014 From IDLE, frame_start=1 SHALL go to SHIFT with the bit counter cleared to 0 and the shift register cleared to all zeros.
REQ-015 In SHIFT, each edge with shift_en=1 SHALL shift in serial_in per SHIFT_LEFT and increment the counter.
- Edges with shift_en=0 change nothing.
REQ-016 The edge that samples bit OUTPUT_WIDTH-1 SHALL complete the frame when parity is disabled:
- load data with the assembled word;
- set data_valid=1;
- return to IDLE.
- data and data_valid are therefore visible one cycle after the final sampling edge.
REQ-017 frame_start=1 while in SHIFT or PARITY SHALL discard the partial frame and restart per REQ-014.
- frame_start takes priority over a simultaneous shift_en sample.
REQ-018 frame_start in IDLE with shift_en=1 in the same cycle SHALL only arm; that cycle's serial_in is not sampled.
REQ-019 data_ack=1 while data_valid=1 SHALL clear data_valid on the next edge.
- data_ack while data_valid=0 is ignored.
REQ-020 If a frame completes on the same edge as data_ack with data_valid=1, the new word SHALL load and data_valid SHALL remain 1, with no overrun.
REQ-021 If a frame completes while data_valid=1 and data_ack=0:
- data SHALL be overwritten with the new word;
- data_valid SHALL stay 1;
- overrun SHALL set.
REQ-022 overrun SHALL clear only on reset.
REQ-023 The bit counter SHALL be $clog2(OUTPUT_WIDTH+1) bits wide and SHALL never wrap within a frame.

Reset
REQ-024 When rst_n=0 at an edge, the block SHALL force:
- state = IDLE;
- counter = 0;
- shift register = 0;
- data = 0;
- data_valid = 0;
- overrun = 0;
- busy = 0;
- parity_err = 0 (when present).
REQ-025 A reset mid-frame SHALL discard the partial frame; the next frame requires a new frame_start.
REQ-026 Reset SHALL take priority over every other input.

Configuration
REQ-027 With SIPO_CAPTURE_PARITY_EN defined:
- after the last data bit the FSM SHALL enter PARITY;
- the next shift_en sample SHALL be an even-parity bit;
- completion per REQ-016 SHALL occur on that edge;
- output port parity_err (1 bit) SHALL be updated with every loaded word (1 = parity mismatch) and SHALL clear with data_valid on acknowledge.
REQ-028 Without SIPO_CAPTURE_PARITY_EN: no PARITY state, no parity_err port, and frames are exactly OUTPUT_WIDTH bits.

Structure
REQ-029 Package sipo_pkg SHALL hold:
- the FSM state enum (IDLE, SHIFT, PARITY);
- a function computing the counter width.
REQ-030 The shift register datapath SHALL be a sub-module sipo_shifter.
- Inputs: clk, rst_n, clear, shift_en, serial_in; parameters OUTPUT_WIDTH and SHIFT_LEFT.
- Outputs: the word.
- The FSM, counter and holding register stay in sipo_capture.

Verification
REQ-031 MSB-first: SHIFT_LEFT=1, frame_start, then bits 1,1,0,1,1,0,0,0 on consecutive shift_en cycles -> data=8'b11011000 and data_valid=1 the cycle after the 8th edge; busy=0.
REQ-032 LSB-first: SHIFT_LEFT=0, same bit stream -> data=8'b00011011.
REQ-033 Frame 8'b00101000 completes with data_valid=1 and no ack, then frame 8'b11011000 completes -> data=8'b11011000, overrun=1; a following ack clears data_valid, and overrun stays 1.
REQ-034 frame_start after 4 bits of 1010, then a full frame 8'hA5 -> data=8'hA5; the partial bits are absent.
REQ-035 rst_n=0 for one edge after 5 bits -> all outputs 0; 8 further shift_en bits with no frame_start -> data_valid stays 0.
REQ-036 With SIPO_CAPTURE_PARITY_EN: 8'hA5 with parity bit 0 -> parity_err=0; 8'hA5 with parity bit 1 -> parity_err=1; ack -> parity_err=0.
